// File: rtl/wrapper_pkg.sv
// Shared defaults and direction encoding for the up/down LED counter.
package wrapper_pkg;
    localparam int   WIDTH_DEF    = 4;
    localparam int   TICK_DIV_DEF = 100_000_000;
    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
endpackage

// File: rtl/wrapper_module_tick_gen.sv
// Free-running divider: counts 0..TICK_DIV-1 and raises tick for the final cycle.
module tick_gen
    import wrapper_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_btn,
    output logic tick
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/wrapper_module.sv
// Up/down LED counter stepping once per TICK_DIV cycles; sw0 selects direction.
module wrapper_module
    import wrapper_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             sw0,
    output logic [WIDTH-1:0] led
);
    logic             sw_meta;
    logic             sw_sync;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_btn(rst_btn),
        .tick   (tick)
    );

    // sw0 is asynchronous; two flops before it steers the counter. Reset parks it at up.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            sw_meta <= DIR_UP;
            sw_sync <= DIR_UP;
        end else begin
            sw_meta <= sw0;
            sw_sync <= sw_meta;
        end
    end

    // Natural modular wrap in both directions.
    always_comb begin
        count_next = count;
        if (tick) begin
            if (sw_sync == DIR_UP) begin
                count_next = count + 1'b1;
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign led = count;
endmodule

// File: tb/tb_wrapper_module.sv
// Directed bench for wrapper_module with a cycle-level reference model and scoreboard.
module tb_wrapper_module;
    localparam int TD    = 10;
    localparam int W     = 4;
    localparam int MODV  = 1 << W;

    logic         clk;
    logic         rst_btn;
    logic         sw0;
    logic [W-1:0] led;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [W-1:0] exp_q[$];

    wrapper_module #(
        .TICK_DIV(TD),
        .WIDTH   (W)
    ) dut (
        .clk    (clk),
        .rst_btn(rst_btn),
        .sw0    (sw0),
        .led    (led)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_btn = 1'b0;
        sw0     = 1'b1;
    end

    // Reference model: steps every TD edges after release, direction is the
    // sw0 level seen two edges earlier (up while in reset).
    int   m_count = 0;
    int   m_edges = 0;
    logic m_hist0 = 1'b1;
    logic m_hist1 = 1'b1;

    always @(posedge clk) begin
        if (!rst_btn) begin
            m_count = 0;
            m_edges = 0;
            m_hist0 = 1'b1;
            m_hist1 = 1'b1;
        end else begin
            m_edges = m_edges + 1;
            if (m_edges % TD == 0) begin
                if (m_hist1) m_count = (m_count + 1) % MODV;
                else         m_count = (m_count + MODV - 1) % MODV;
            end
            m_hist1 = m_hist0;
            m_hist0 = sw0;
        end
        exp_q.push_back(W'(m_count));
    end

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (led !== e) begin
                cmp_cnt++;
                fail_cnt++;
                $display("FAIL sb_led: got %0d expected %0d at %0t", led, e, $time);
            end else begin
                cmp_cnt++;
            end
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic dir);
        rst_btn = 1'b0;
        sw0     = dir;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("led_in_reset", int'(led), 0);
            if (i == 2) sw0 = ~dir;
            if (i == 3) sw0 = dir;
        end
        rst_btn = 1'b1;
    endtask

    initial begin
        // Reset then count up; first step on the 10th edge after release
        do_reset(1'b1);
        step(9);  check("pre_first_tick", int'(led), 0);
        step(1);  check("first_tick", int'(led), 1);
        step(10); check("second_tick", int'(led), 2);

        // Up wrap
        step(130); check("up_15", int'(led), 15);
        step(9);   check("up_hold_15", int'(led), 15);
        step(1);   check("up_wrap_0", int'(led), 0);

        // Down wrap from reset
        do_reset(1'b0);
        step(10); check("down_wrap_15", int'(led), 15);
        step(10); check("down_14", int'(led), 14);

        // Direction flip three cycles after reaching 5
        do_reset(1'b1);
        step(50); check("flip_at_5", int'(led), 5);
        step(3);  sw0 = 1'b0;
        step(6);  check("flip_hold_5", int'(led), 5);
        step(1);  check("flip_down_4", int'(led), 4);
        step(9);  check("flip_hold_4", int'(led), 4);
        step(1);  check("flip_down_3", int'(led), 3);

        // Mid-run reset at 7
        do_reset(1'b1);
        step(70); check("mid_at_7", int'(led), 7);
        rst_btn = 1'b0;
        step(1);  check("mid_reset_0", int'(led), 0);
        step(4);  check("mid_reset_hold", int'(led), 0);
        rst_btn = 1'b1;
        step(9);  check("mid_pre_tick", int'(led), 0);
        step(1);  check("mid_first_tick", int'(led), 1);

        // Sub-cycle glitch never sampled, then a one-cycle pulse that is
        do_reset(1'b1);
        step(10); check("glitch_at_1", int'(led), 1);
        step(3);  sw0 = 1'b0; #3 sw0 = 1'b1;
        step(7);  check("glitch_ignored", int'(led), 2);
        step(7);  sw0 = 1'b0;
        step(1);  sw0 = 1'b1;
        step(2);  check("pulse_down_1", int'(led), 1);
        step(10); check("pulse_up_2", int'(led), 2);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/wrapper_module.md
WRAPPER_MODULE -- requirements
Module: wrapper_module

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clock cycles per count step (>= 2); benches override to 10.
REQ-002 Parameter WIDTH, default 4, counter/LED width.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_btn  input  1  synchronous, active-low reset.
REQ-005 sw0  input  1  direction switch, asynchronous to clk: 1 = count up, 0 = count down.
REQ-006 led  output  WIDTH  current counter value, registered.

Function
REQ-007 sw0 SHALL pass through a 2-flop synchronizer before use; direction reaches the counter 2 cycles after an sw0 change.
REQ-008 A divider counter div_cnt SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-009 A one-cycle tick SHALL assert in the cycle div_cnt == TICK_DIV-1.
REQ-010 On a tick edge, count SHALL step by 1 in the synchronized direction; no tick -> count holds.
REQ-011 Up-count wrap: 2^WIDTH-1 -> 0; down-count wrap: 0 -> 2^WIDTH-1; no saturation, no flags.
REQ-012 Direction change between ticks SHALL only affect the next tick; no extra or lost steps; divider phase unaffected.
REQ-013 led SHALL equal count every cycle (no extra latency beyond the count register).
REQ-014 First step after reset release SHALL occur on the TICK_DIV-th rising edge with rst_btn high.
REQ-015 Step period SHALL be exactly TICK_DIV cycles in steady state, independent of direction.

Reset
REQ-016 rst_btn low at a rising edge SHALL set count = 0, div_cnt = 0, both synchronizer flops = 1 (up).
REQ-017 Reset SHALL be synchronous only; no asynchronous clearing of any flop.
REQ-018 Reset mid-operation SHALL abandon current divider phase; led = 0 on the edge after rst_btn is sampled low; counting restarts per REQ-014.
REQ-019 While rst_btn is held low, led SHALL stay 0 regardless of sw0.

Structure
REQ-020 Shared package wrapper_pkg SHALL hold WIDTH default, TICK_DIV default and the direction encoding constants (DIR_UP = 1, DIR_DOWN = 0).
REQ-021 Divider and tick generation SHALL be one sub-module tick_gen (params TICK_DIV; ports clk, rst_btn, tick); synchronizer and up/down counter stay in wrapper_module.
REQ-022 div_cnt width SHALL be $clog2(TICK_DIV).

Verification (TICK_DIV = 10, WIDTH = 4, 10 ns clock)
REQ-023 rst_btn low 5 cycles, sw0 = 1 -> led = 0 throughout reset; release -> led = 1 on the 10th edge, 2 on the 20th.
REQ-024 Up wrap: hold sw0 = 1 for 160 cycles after release -> led reaches 15 at edge 150, 0 at edge 160.
REQ-025 Down wrap: from reset release with sw0 = 0 (stable >= 2 cycles) -> led = 15 at edge 10, 14 at edge 20.
REQ-026 Direction flip: count up to led = 5, set sw0 = 0 three cycles after that step -> next tick gives 4, step spacing stays 10 cycles.
REQ-027 Mid-run reset: at led = 7, rst_btn low 5 cycles -> led = 0 on the edge after first low sample, then led = 1 exactly 10 edges after release.
REQ-028 sw0 toggled twice within 1 cycle between ticks -> no glitch on led, only the value synchronized at the tick is used.
